rk8e_dbreak: RTL and testbench

Data-break initiator for the RK8E disk path. Moves one sector (128 or 256 words) between the disk-side word streams and PDP-8 core memory by requesting CPU break cycles and driving the memory-address unit's DMA inputs during DB0–DB3. It sits between the RK8E disk controller and the CPU: it feeds `dmaAddr`/`disk2mem`/`to_disk`, consumes `mem2disk`, and watches the CPU major state.

---
 rtl/rk8e_dbreak_pkg.sv | 22 ++
 rtl/rk8e_dbreak.sv | 167 ++++++++++++++++
 tb/tb_rk8e_dbreak.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rk8e_dbreak_pkg.sv
// Shared parameters for the RK8E data-break path: CPU break-cycle major-state
// codes, the initiator's FSM encoding and the sector word counts.
package rk8e_dbreak_pkg;

    // CPU major-state codes for the four data-break cycles
    localparam logic [4:0] DB0 = 5'd16;
    localparam logic [4:0] DB1 = 5'd17;
    localparam logic [4:0] DB2 = 5'd18;
    localparam logic [4:0] DB3 = 5'd19;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        REQ   = 3'd2,
        XFER  = 3'd3,
        DRAIN = 3'd4
    } fsm_t;

    localparam logic [8:0] WORDS_FULL = 9'd256;
    localparam logic [8:0] WORDS_HALF = 9'd128;

endpackage

// File: rtl/rk8e_dbreak.sv
// Data-break initiator: moves one disk sector between the disk word streams and
// PDP-8 core by requesting CPU break cycles and driving the DMA address/data.
module rk8e_dbreak
    import rk8e_dbreak_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        dir,
    input  logic        half,
    input  logic [0:14] base_addr,
    input  logic [4:0]  state,
    output logic        break_req,
    output logic [0:14] dmaAddr,
    output logic [0:11] disk2mem,
    output logic        to_disk,
    input  logic [0:11] mem2disk,
    input  logic [11:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [11:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        done
);

    fsm_t        fsm_reg, fsm_next;
    logic [8:0]  count_reg, count_next;
    logic        break_req_reg, break_req_next;
    logic [0:14] dma_addr_reg, dma_addr_next;
    logic [0:11] disk2mem_reg, disk2mem_next;
    logic        to_disk_reg, to_disk_next;
    logic        s_ready_reg, s_ready_next;
    logic [11:0] m_data_reg, m_data_next;
    logic        m_valid_reg, m_valid_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg       <= IDLE;
            count_reg     <= '0;
            break_req_reg <= 1'b0;
            dma_addr_reg  <= '0;
            disk2mem_reg  <= '0;
            to_disk_reg   <= 1'b0;
            s_ready_reg   <= 1'b0;
            m_data_reg    <= '0;
            m_valid_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            fsm_reg       <= fsm_next;
            count_reg     <= count_next;
            break_req_reg <= break_req_next;
            dma_addr_reg  <= dma_addr_next;
            disk2mem_reg  <= disk2mem_next;
            to_disk_reg   <= to_disk_next;
            s_ready_reg   <= s_ready_next;
            m_data_reg    <= m_data_next;
            m_valid_reg   <= m_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // to_disk_reg doubles as the latched transfer direction while busy
    always_comb begin
        fsm_next       = fsm_reg;
        count_next     = count_reg;
        break_req_next = break_req_reg;
        dma_addr_next  = dma_addr_reg;
        disk2mem_next  = disk2mem_reg;
        to_disk_next   = to_disk_reg;
        s_ready_next   = s_ready_reg;
        m_data_next    = m_data_reg;
        m_valid_next   = m_valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        case (fsm_reg)
            IDLE: begin
                if (go) begin
                    to_disk_next  = dir;
                    dma_addr_next = base_addr;
                    count_next    = half ? WORDS_HALF : WORDS_FULL;
                    busy_next     = 1'b1;
                    if (dir) begin
                        fsm_next = REQ;
                    end else begin
                        s_ready_next = 1'b1;
                        fsm_next     = FILL;
                    end
                end
            end

            FILL: begin
                if (s_valid && s_ready_reg) begin
                    disk2mem_next = s_data;
                    s_ready_next  = 1'b0;
                    fsm_next      = REQ;
                end
            end

            // Only a DB0 answering our own outstanding request counts as a grant
            REQ: begin
                if (break_req_reg && state == DB0) begin
                    break_req_next = 1'b0;
                    fsm_next       = XFER;
                end else begin
                    break_req_next = 1'b1;
                end
            end

            XFER: begin
                if (state == DB3) begin
                    dma_addr_next = {dma_addr_reg[0:2], dma_addr_reg[3:14] + 12'd1};
                    if (to_disk_reg) begin
                        m_data_next  = mem2disk;
                        m_valid_next = 1'b1;
                        fsm_next     = DRAIN;
                    end else begin
                        count_next = count_reg - 9'd1;
                        if (count_reg == 9'd1) begin
                            done_next    = 1'b1;
                            busy_next    = 1'b0;
                            to_disk_next = 1'b0;
                            fsm_next     = IDLE;
                        end else begin
                            s_ready_next = 1'b1;
                            fsm_next     = FILL;
                        end
                    end
                end
            end

            DRAIN: begin
                if (m_valid_reg && m_ready) begin
                    m_valid_next = 1'b0;
                    count_next   = count_reg - 9'd1;
                    if (count_reg == 9'd1) begin
                        done_next    = 1'b1;
                        busy_next    = 1'b0;
                        to_disk_next = 1'b0;
                        fsm_next     = IDLE;
                    end else begin
                        fsm_next = REQ;
                    end
                end
            end

            default: fsm_next = IDLE;
        endcase
    end

    assign break_req = break_req_reg;
    assign dmaAddr   = dma_addr_reg;
    assign disk2mem  = disk2mem_reg;
    assign to_disk   = to_disk_reg;
    assign s_ready   = s_ready_reg;
    assign m_data    = m_data_reg;
    assign m_valid   = m_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_rk8e_dbreak.sv
// Scoreboard bench for rk8e_dbreak: a CPU/core model grants breaks and performs
// the memory side, stream drivers feed/consume the disk side.
module tb_rk8e_dbreak;
    import rk8e_dbreak_pkg::*;

    localparam logic [4:0] ST_FETCH = 5'd0;

    logic        clk;
    logic        reset;
    logic        go;
    logic        dir;
    logic        half;
    logic [0:14] base_addr;
    logic [4:0]  state;
    logic        break_req;
    logic [0:14] dmaAddr;
    logic [0:11] disk2mem;
    logic        to_disk;
    logic [0:11] mem2disk;
    logic [11:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;

    rk8e_dbreak dut (
        .clk(clk), .reset(reset), .go(go), .dir(dir), .half(half),
        .base_addr(base_addr), .state(state), .break_req(break_req),
        .dmaAddr(dmaAddr), .disk2mem(disk2mem), .to_disk(to_disk),
        .mem2disk(mem2disk), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] mem [0:32767];
    logic [11:0] s_words [0:255];
    logic [26:0] exp_wr_q [$];
    logic [11:0] exp_m_q [$];

    int n_cmp, n_bad;
    int done_count, db0_count, m_hs_count;
    int first_delay, stable_bad;
    int s_idx, s_len, gap_at, gap_left, gap_breq;
    logic s_hs;
    logic m_toggle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got an unexpected transfer, required none", name);
    endtask

    function automatic logic [0:14] addr_at(input logic [0:14] b, input int i);
        logic [0:14] a;
        a = b;
        a[3:14] = a[3:14] + 12'(i);
        return a;
    endfunction

    // CPU / core model: grants breaks, writes core in DB1, presents read data in DB3
    initial begin
        int phase;
        int waitc;
        logic [30:0] snap;
        logic [30:0] now;
        state = ST_FETCH;
        mem2disk = '0;
        phase = 0;
        waitc = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            now = {dmaAddr, disk2mem, to_disk, m_valid, busy, s_ready};
            if (reset) begin
                state = ST_FETCH;
                phase = 0;
                waitc = 0;
            end else begin
                case (phase)
                    0: begin
                        state = ST_FETCH;
                        if (break_req) begin
                            if (waitc == 0) snap = now;
                            else if (snap !== now) stable_bad++;
                            if (waitc >= first_delay) begin
                                state = DB0;
                                phase = 1;
                                waitc = 0;
                                first_delay = 0;
                                db0_count++;
                            end else begin
                                waitc++;
                            end
                        end else if (waitc != 0) begin
                            stable_bad++;
                            waitc = 0;
                        end
                    end
                    1: begin
                        state = DB1;
                        phase = 2;
                        if (!to_disk) begin
                            mem[dmaAddr] = disk2mem;
                            if (exp_wr_q.size() == 0) unexpected("mem_write");
                            else chk("mem_write", {5'd0, dmaAddr, disk2mem}, {5'd0, exp_wr_q.pop_front()});
                        end
                    end
                    2: begin
                        state = DB2;
                        phase = 3;
                    end
                    default: begin
                        state = DB3;
                        mem2disk = mem[dmaAddr];
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // Disk->memory stream source, with an optional stall while the DUT is ready
    initial begin
        s_valid = 1'b0;
        s_data = '0;
        s_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                s_hs = 1'b0;
                s_valid = 1'b0;
            end else begin
                if (s_hs) s_idx++;
                if (s_idx == gap_at && gap_left > 0) begin
                    s_valid = 1'b0;
                    if (s_ready) begin
                        gap_left--;
                        if (break_req) gap_breq++;
                    end
                end else begin
                    s_valid = (s_idx < s_len);
                    s_data = (s_idx < s_len) ? s_words[s_idx] : 12'd0;
                end
                s_hs = s_valid && s_ready;
            end
        end
    end

    // Memory->disk stream sink and monitor
    initial begin
        int cyc;
        cyc = 0;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            m_ready = m_toggle ? cyc[0] : 1'b1;
            if (!reset && m_valid && m_ready) begin
                m_hs_count++;
                if (exp_m_q.size() == 0) unexpected("m_data");
                else chk("m_data", {20'd0, m_data}, {20'd0, exp_m_q.pop_front()});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_count++;
        end
    end

    task automatic clear_counts();
        done_count = 0;
        db0_count = 0;
        m_hs_count = 0;
    endtask

    task automatic prep_d2m(input logic [0:14] b, input int n, input int seed);
        exp_wr_q.delete();
        for (int i = 0; i < n; i++) begin
            s_words[i] = 12'((i * 37 + seed) & 'hFFF);
            exp_wr_q.push_back({addr_at(b, i), s_words[i]});
        end
        s_idx = 0;
        s_len = n;
    endtask

    task automatic prep_m2d(input logic [0:14] b, input int n);
        exp_m_q.delete();
        for (int i = 0; i < n; i++) exp_m_q.push_back(mem[addr_at(b, i)]);
    endtask

    task automatic start(input logic d, input logic h, input logic [0:14] b);
        @(negedge clk); #1;
        dir = d;
        half = h;
        base_addr = b;
        go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int k;
        k = 0;
        while (done_count < 1 && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        if (done_count < 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timed out after %0d cycles, done count %0d, required 1", name, k, done_count);
        end
        repeat (20) @(negedge clk);
        #1;
    endtask

    task automatic end_checks(input string name, input int words, input logic [0:14] b);
        chk({name, "_done_pulses"}, 32'(done_count), 32'd1);
        chk({name, "_db0_count"}, 32'(db0_count), 32'(words));
        chk({name, "_final_addr"}, {17'd0, dmaAddr}, {17'd0, addr_at(b, words)});
        chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({name, "_to_disk_low"}, {31'd0, to_disk}, 32'd0);
        $display("xfer %s: words=%0d base=%05o db0=%0d done=%0d end_addr=%05o",
                 name, words, b, db0_count, done_count, dmaAddr);
    endtask

    initial begin
        int bad;
        int k;
        n_cmp = 0; n_bad = 0;
        clear_counts();
        first_delay = 0; stable_bad = 0;
        s_idx = 0; s_len = 0; gap_at = -1; gap_left = 0; gap_breq = 0;
        m_toggle = 1'b0;
        reset = 1'b1; go = 1'b0; dir = 1'b0; half = 1'b0; base_addr = '0;
        for (int a = 0; a < 32768; a++) mem[a] = 12'(((a * 7) ^ (a >> 5) ^ 'h5A5) & 'hFFF);

        repeat (5) @(negedge clk);
        #1;
        chk("rst_break_req", {31'd0, break_req}, 32'd0);
        chk("rst_dmaAddr", {17'd0, dmaAddr}, 32'd0);
        chk("rst_disk2mem", {20'd0, disk2mem}, 32'd0);
        chk("rst_to_disk", {31'd0, to_disk}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {20'd0, m_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // Disk->memory, 128 words at 1:0200
        clear_counts();
        prep_d2m(15'o10200, 128, 5);
        start(1'b0, 1'b1, 15'o10200);
        chk("d2m_busy", {31'd0, busy}, 32'd1);
        chk("d2m_to_disk", {31'd0, to_disk}, 32'd0);
        wait_done("d2m", 3000);
        end_checks("d2m", 128, 15'o10200);
        chk("d2m_writes_left", 32'(exp_wr_q.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[addr_at(15'o10200, i)] !== s_words[i]) bad++;
        chk("d2m_core_contents", 32'(bad), 32'd0);

        // Memory->disk, 256 words at 0:7700, wrapping within field 0
        clear_counts();
        m_toggle = 1'b1;
        prep_m2d(15'o07700, 256);
        start(1'b1, 1'b0, 15'o07700);
        chk("m2d_to_disk", {31'd0, to_disk}, 32'd1);
        wait_done("m2d", 8000);
        end_checks("m2d", 256, 15'o07700);
        chk("m2d_words_out", 32'(m_hs_count), 32'd256);
        chk("m2d_words_left", 32'(exp_m_q.size()), 32'd0);
        m_toggle = 1'b0;

        // First grant held off 20 cycles
        clear_counts();
        stable_bad = 0;
        first_delay = 20;
        prep_m2d(15'o20000, 128);
        start(1'b1, 1'b1, 15'o20000);
        wait_done("delay", 4000);
        end_checks("delay", 128, 15'o20000);
        chk("delay_stable", 32'(stable_bad), 32'd0);
        chk("delay_words_out", 32'(m_hs_count), 32'd128);
        chk("delay_words_left", 32'(exp_m_q.size()), 32'd0);

        // Stream stalls 10 cycles before word 60
        clear_counts();
        prep_d2m(15'o30100, 128, 900);
        gap_at = 60; gap_left = 10; gap_breq = 0;
        start(1'b0, 1'b1, 15'o30100);
        wait_done("gap", 4000);
        end_checks("gap", 128, 15'o30100);
        chk("gap_taken", 32'(gap_left), 32'd0);
        chk("gap_no_break_req", 32'(gap_breq), 32'd0);
        chk("gap_writes_left", 32'(exp_wr_q.size()), 32'd0);
        gap_at = -1;

        // Reset during DB1 of the fifth break, then a clean restart
        clear_counts();
        prep_d2m(15'o40000, 128, 77);
        start(1'b0, 1'b1, 15'o40000);
        k = 0;
        while (!(db0_count == 5 && state == DB1) && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("rst5_reached_db1", {31'd0, (db0_count == 5 && state == DB1)}, 32'd1);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rst5_break_req", {31'd0, break_req}, 32'd0);
        chk("rst5_dmaAddr", {17'd0, dmaAddr}, 32'd0);
        chk("rst5_disk2mem", {20'd0, disk2mem}, 32'd0);
        chk("rst5_busy", {31'd0, busy}, 32'd0);
        chk("rst5_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst5_writes_left", 32'(exp_wr_q.size()), 32'd123);
        reset = 1'b0;
        $display("xfer rst5: reset at break 5, %0d words written", 128 - exp_wr_q.size());
        clear_counts();
        prep_d2m(15'o50200, 128, 333);
        start(1'b0, 1'b1, 15'o50200);
        wait_done("restart", 3000);
        end_checks("restart", 128, 15'o50200);
        chk("restart_writes_left", 32'(exp_wr_q.size()), 32'd0);

        // go while busy must be ignored
        clear_counts();
        prep_m2d(15'o60000, 128);
        start(1'b1, 1'b1, 15'o60000);
        repeat (10) @(negedge clk);
        #1;
        dir = 1'b0; half = 1'b0; base_addr = 15'o71234; go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("gobusy_to_disk", {31'd0, to_disk}, 32'd1);
        chk("gobusy_field", {29'd0, dmaAddr[0:2]}, 32'd6);
        wait_done("gobusy", 4000);
        end_checks("gobusy", 128, 15'o60000);
        chk("gobusy_words_out", 32'(m_hs_count), 32'd128);
        chk("gobusy_words_left", 32'(exp_m_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
